// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program-counter width and the next-PC select
// encodings. The control unit imports the same constants so the encodings
// are defined in exactly one place.
package cpu_pkg;

  localparam int PC_W = 10;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_JMP  = 2'b01,
    PC_RET  = 2'b10,
    PC_HOLD = 2'b11
  } s_pc_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the control unit (master) and the
// program-counter unit (slave). Parameters must match the pc_unit instance.
interface pc_unit_if #(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int DEPTH = 16
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 enable_pc;
  cpu_pkg::s_pc_e       s_pc;
  logic                 push;
  logic                 pop;
  logic [PC_W-1:0]      jump_addr;
  logic [PC_W-1:0]      pc;
  logic [CNT_W-1:0]     sp_count;
  logic                 empty;
  logic                 full;
  logic                 stk_ovf;
  logic                 stk_unf;

  modport master (
    output enable_pc, s_pc, push, pop, jump_addr,
    input  pc, sp_count, empty, full, stk_ovf, stk_unf
  );

  modport slave (
    input  enable_pc, s_pc, push, pop, jump_addr,
    output pc, sp_count, empty, full, stk_ovf, stk_unf
  );

endinterface

// File: rtl/pc_unit_return_stack.sv
// return_stack: circular-buffer return-address stack with entry count.
// Build option STACK_ERR_EN: when defined, push on full is dropped and sets
// a sticky overflow flag, pop on empty is refused and sets a sticky
// underflow flag. When undefined, push on full overwrites the oldest entry,
// pop on empty rewinds the pointer onto a stale entry, and both flags are 0.
module return_stack #(
  parameter  int PC_W  = cpu_pkg::PC_W,
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  wr_data,
  output logic [PC_W-1:0]  top,
  output logic             ret_bad,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  // DEPTH is a power of two, so the pointer wraps naturally.
  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wr_en;
`ifdef STACK_ERR_EN
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_q;
  logic             unf_q;
`endif

  // ptr addresses the next free slot; the top entry sits just below it.
  assign top_idx = ptr - 1'b1;
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));

`ifdef STACK_ERR_EN
  // A refused pop must not hand a stale entry to the PC mux.
  assign ret_bad = pop && empty;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
`else
  assign ret_bad = 1'b0;
  assign ovf     = 1'b0;
  assign unf     = 1'b0;
`endif

  // Next pointer, count and write decision for this cycle's push/pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    wr_en   = 1'b0;
    wr_idx  = ptr;
    ptr_nxt = ptr;
    cnt_nxt = count;
`ifdef STACK_ERR_EN
    ovf_set = 1'b0;
    unf_set = 1'b0;
`endif
    if (en) begin
      if (pop && empty) begin
        // Pop on empty wins over a simultaneous push.
`ifdef STACK_ERR_EN
        unf_set = 1'b1;
`else
        ptr_nxt = ptr - 1'b1;
`endif
      end else if (push && pop) begin
        // Swap: replace the top in place, depth unchanged.
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push) begin
        if (full) begin
`ifdef STACK_ERR_EN
          ovf_set = 1'b1;
`else
          // With a full ring, ptr already points at the oldest entry.
          wr_en   = 1'b1;
          ptr_nxt = ptr + 1'b1;
`endif
        end else begin
          wr_en   = 1'b1;
          ptr_nxt = ptr + 1'b1;
          cnt_nxt = count + 1'b1;
        end
      end else if (pop) begin
        ptr_nxt = ptr - 1'b1;
        cnt_nxt = count - 1'b1;
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else begin
      ptr   <= ptr_nxt;
      count <= cnt_nxt;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count=0 already marks every entry invalid.
    if (!reset && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

`ifdef STACK_ERR_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter register and next-PC multiplexer with a return
// stack for JAL/JR. Build option STACK_ERR_EN (see return_stack) selects
// refuse-and-flag stack error handling instead of wrap-around behaviour.
module pc_unit #(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);

  import cpu_pkg::*;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] stack_top;
  logic            ret_bad;

  // Wraps modulo 2^PC_W; also the return address pushed by JAL.
  assign pc_plus1 = pc_q + 1'b1;

  return_stack #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .en      (bus.enable_pc),
    .push    (bus.push),
    .pop     (bus.pop),
    .wr_data (pc_plus1),
    .top     (stack_top),
    .ret_bad (ret_bad),
    .count   (bus.sp_count),
    .empty   (bus.empty),
    .full    (bus.full),
    .ovf     (bus.stk_ovf),
    .unf     (bus.stk_unf)
  );

  // Next-PC select.
  always_comb begin
    pc_nxt = pc_q;
    case (bus.s_pc)
      PC_INC:  pc_nxt = pc_plus1;
      PC_JMP:  pc_nxt = bus.jump_addr;
      PC_RET:  pc_nxt = ret_bad ? pc_plus1 : stack_top;
      PC_HOLD: pc_nxt = pc_q;
      default: pc_nxt = pc_q;
    endcase
  end

  // PC register; updates only when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else if (bus.enable_pc) begin
      pc_q <= pc_nxt;
    end
  end

  assign bus.pc = pc_q;

endmodule
